// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the ALU itself:
// op codes, RV64I major opcodes, funct7 patterns and the issue payload.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_ADDW = 4'hA,
    ALU_SUBW = 4'hB,
    ALU_SLLW = 4'hC,
    ALU_SRLW = 4'hD,
    ALU_SRAW = 4'hE
  } alu_op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // RV64 immediate shifts steal inst[25] for shamt, so only 6 funct bits remain
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  // Decoded instruction as handed to the ALU
  typedef struct packed {
    alu_op_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } alu_req_t;

  // funct3 -> op for the base-encoding (funct7 = 0) register/immediate forms
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV64I integer decode: instruction + operands -> ALU request.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  output alu_req_t    req
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] imm_i;
  logic [63:0] imm_u;
  logic [63:0] shamt6;
  logic [63:0] shamt5;
  logic        legal;
  alu_op_e     op;
  logic [63:0] a;
  logic [63:0] b;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{52{inst[31]}}, inst[31:20]};
  assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {58'b0, inst[25:20]};
  assign shamt5 = {59'b0, inst[24:20]};

  // Classify the opcode/funct combination and pick operands
  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    a     = '0;
    b     = '0;
    case (opc)
      OPC_OP: begin
        a = rs1_data;
        b = rs2_data;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          op    = base_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal = 1'b1;
          op    = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal = 1'b1;
          op    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        a = rs1_data;
        case (f3)
          3'b001: begin
            b     = shamt6;
            op    = ALU_SLL;
            legal = (inst[31:26] == F6_BASE);
          end
          3'b101: begin
            b = shamt6;
            if (inst[31:26] == F6_BASE) begin
              legal = 1'b1;
              op    = ALU_SRL;
            end else if (inst[31:26] == F6_ALT) begin
              legal = 1'b1;
              op    = ALU_SRA;
            end
          end
          default: begin
            b     = imm_i;
            legal = 1'b1;
            op    = base_op(f3);
          end
        endcase
      end
      OPC_OP_32: begin
        a = rs1_data;
        b = rs2_data;
        case (f3)
          3'b000: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            op    = (f7 == F7_ALT) ? ALU_SUBW : ALU_ADDW;
          end
          3'b001: begin
            legal = (f7 == F7_BASE);
            op    = ALU_SLLW;
          end
          3'b101: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            op    = (f7 == F7_ALT) ? ALU_SRAW : ALU_SRLW;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        a = rs1_data;
        case (f3)
          3'b000: begin
            legal = 1'b1;
            op    = ALU_ADDW;
            b     = imm_i;
          end
          3'b001: begin
            legal = (f7 == F7_BASE);
            op    = ALU_SLLW;
            b     = shamt5;
          end
          3'b101: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            op    = (f7 == F7_ALT) ? ALU_SRAW : ALU_SRLW;
            b     = shamt5;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc;
        b     = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings still flow down the pipe, but with neutral operands
  always_comb begin
    req.op      = legal ? op : ALU_ADD;
    req.a       = legal ? a : '0;
    req.b       = legal ? b : '0;
    req.rd      = inst[11:7];
    req.we      = legal && (inst[11:7] != 5'd0);
    req.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a single-entry valid/ready register with
// flush and an issued-instruction counter.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  alu_req_t         dec_req;
  alu_req_t         req_q, req_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;
  logic             handoff;

  alu_issue_decode u_decode (
    .inst     (inst),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .req      (dec_req)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign handoff  = valid_q && out_ready;

  // Next state: flush wins, then capture (which also covers handoff+capture),
  // then a plain handoff drains the entry. Payload only moves on capture so
  // it holds stable under backpressure.
  always_comb begin
    req_d   = req_q;
    valid_d = valid_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, handoff};
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      req_d   = dec_req;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register and counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = req_q.op;
  assign out_a       = req_q.a;
  assign out_b       = req_q.b;
  assign out_rd      = req_q.rd;
  assign out_we      = req_q.we;
  assign out_illegal = req_q.illegal;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode/handshake
// scenarios plus randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk, rstn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data, out_a, out_b, issued_cnt;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic         m_valid;
  logic [139:0] m_exp;
  logic [63:0]  m_cnt;

  wire [139:0] dut_pl = {out_alu_op, out_a, out_b, out_rd, out_we, out_illegal};

  alu_issue_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_we(out_we), .out_illegal(out_illegal), .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the ISA rules: returns {op,a,b,rd,we,illegal}
  function automatic logic [139:0] ref_decode(input logic [31:0] i, input logic [63:0] p,
                                              input logic [63:0] x1, input logic [63:0] x2);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] immi, immu, a, b;
    logic [3:0]  base [8];
    int          op;
    opc  = i[6:0];
    f3   = i[14:12];
    f7   = i[31:25];
    immi = {{52{i[31]}}, i[31:20]};
    immu = {{32{i[31]}}, i[31:12], 12'h000};
    base = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
    op = -1;
    a  = 64'd0;
    b  = 64'd0;
    case (opc)
      7'h33: begin
        a = x1; b = x2;
        if (f7 == 7'h00) op = int'(base[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) op = 9;
      end
      7'h13: begin
        a = x1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b = {58'd0, i[25:20]};
          if (i[31:26] == 6'h00) op = (f3 == 3'd1) ? 7 : 8;
          else if (i[31:26] == 6'h10 && f3 == 3'd5) op = 9;
        end else begin
          b = immi; op = int'(base[f3]);
        end
      end
      7'h3b: begin
        a = x1; b = x2;
        if (f3 == 3'd0 && f7 == 7'h00) op = 10;
        if (f3 == 3'd0 && f7 == 7'h20) op = 11;
        if (f3 == 3'd1 && f7 == 7'h00) op = 12;
        if (f3 == 3'd5 && f7 == 7'h00) op = 13;
        if (f3 == 3'd5 && f7 == 7'h20) op = 14;
      end
      7'h1b: begin
        a = x1;
        b = (f3 == 3'd0) ? immi : {59'd0, i[24:20]};
        if (f3 == 3'd0) op = 10;
        if (f3 == 3'd1 && f7 == 7'h00) op = 12;
        if (f3 == 3'd5 && f7 == 7'h00) op = 13;
        if (f3 == 3'd5 && f7 == 7'h20) op = 14;
      end
      7'h37: begin op = 0; a = 64'd0; b = immu; end
      7'h17: begin op = 0; a = p;     b = immu; end
      default: op = -1;
    endcase
    if (op < 0) return {4'h0, 64'd0, 64'd0, i[11:7], 1'b0, 1'b1};
    return {op[3:0], a, b, i[11:7], (i[11:7] != 5'd0), 1'b0};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [8];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h3b, 7'h1b, 7'h37, 7'h17, 7'h03, 7'h7f};
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:26] = 6'h10;
      default: ;
    endcase
    r[6:0] = opcs[$urandom_range(0, 7)];
    return r;
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, rd, 7'h13};
  endfunction

  // Advance one clock, updating the model from the inputs presented now
  task automatic tick();
    logic h, r;
    h = m_valid && out_ready;
    r = !m_valid || out_ready;
    if (h) m_cnt = m_cnt + 64'd1;
    if (flush) m_valid = 1'b0;
    else if (in_valid && r) begin
      m_valid = 1'b1;
      m_exp   = ref_decode(inst, pc, rs1_data, rs2_data);
    end else if (h) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0; inst = 32'h0;
    pc = 64'h1000; rs1_data = 64'd5; rs2_data = 64'd7;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    m_valid = 0; m_cnt = 0; m_exp = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    #3;
    n_checks++;
    if ({out_valid, dut_pl, issued_cnt} !== '0)
      $display("FAIL reset_state: got valid=%b pl=%h cnt=%0d, want all zero", out_valid, dut_pl, issued_cnt);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_decode();
    logic [31:0] insts [4];
    logic [139:0] want [4];
    insts = '{32'hFFF08293, 32'h402081B3, 32'h4030D09B, 32'h800000B7};
    // hand-derived: addi x5,x1,-1 / sub x3,x1,x2 / sraiw x1,x1,3 / lui x1,0x80000
    want = '{{4'h0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 1'b0},
             {4'h1, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0},
             {4'hE, 64'd5, 64'd3, 5'd1, 1'b1, 1'b0},
             {4'h0, 64'd0, 64'hFFFF_FFFF_8000_0000, 5'd1, 1'b1, 1'b0}};
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; inst = insts[k];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || dut_pl !== want[k])
        $display("FAIL decode_%0d: got v=%b pl=%h want v=1 pl=%h", k, out_valid, dut_pl, want[k]);
      else n_pass++;
      n_checks++;
      if (issued_cnt !== 64'(k)) $display("FAIL decode_cnt_%0d: got %0d want %0d", k, issued_cnt, k);
      else n_pass++;
    end
    in_valid = 0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || issued_cnt !== 64'd4)
      $display("FAIL decode_drain: got v=%b cnt=%0d want v=0 cnt=4", out_valid, issued_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] insts [2];
    logic [4:0]  rds [2];
    insts = '{32'h00000000, 32'h0420D293};
    rds   = '{5'd0, 5'd5};
    do_reset();
    out_ready = 1;
    rs1_data = 64'hDEAD; rs2_data = 64'hBEEF;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; inst = insts[k];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || dut_pl !== {4'h0, 64'd0, 64'd0, rds[k], 1'b0, 1'b1})
        $display("FAIL illegal_%0d: got v=%b pl=%h want illegal rd=%0d", k, out_valid, dut_pl, rds[k]);
      else n_pass++;
    end
    in_valid = 0;
    tick();
    n_checks++;
    if (issued_cnt !== 64'd2) $display("FAIL illegal_cnt: got %0d want 2", issued_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] upq [$];
    logic [4:0]  got [$];
    logic [139:0] first;
    int last_hand;
    do_reset();
    upq = '{addi(5'd1, 12'h011), addi(5'd2, 12'h022), addi(5'd3, 12'h033)};
    first = ref_decode(upq[0], pc, rs1_data, rs2_data);
    last_hand = -1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      in_valid  = (upq.size() > 0);
      if (in_valid) inst = upq[0];
      #1;
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_pl !== first)
          $display("FAIL bp_hold_c%0d: got rdy=%b v=%b pl=%h want rdy=0 v=1 pl=%h",
                   c, in_ready, out_valid, dut_pl, first);
        else n_pass++;
      end
      if (out_valid && out_ready) begin got.push_back(out_rd); last_hand = c; end
      if (in_valid && in_ready) void'(upq.pop_front());
      tick();
      if (upq.size() == 0 && !out_valid) break;
    end
    n_checks++;
    if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3)
      $display("FAIL bp_order: got %0d handoffs want rd 1,2,3", got.size());
    else n_pass++;
    n_checks++;
    if (last_hand != 7) $display("FAIL bp_throughput: last handoff cycle %0d want 7", last_hand);
    else n_pass++;
    n_checks++;
    if (issued_cnt !== 64'd3) $display("FAIL bp_cnt: got %0d want 3", issued_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; inst = addi(5'd4, 12'h004);
    tick();
    in_valid = 1; inst = addi(5'd6, 12'h006); flush = 1; out_ready = 0;
    #1;
    tick();
    flush = 0; in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b0 || issued_cnt !== 64'd0)
      $display("FAIL flush_held: got v=%b cnt=%0d want v=0 cnt=0", out_valid, issued_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_dropped: got v=%b want 0", out_valid);
    else n_pass++;
    // handoff coinciding with flush still counts
    in_valid = 1; inst = addi(5'd7, 12'h007);
    tick();
    in_valid = 1; flush = 1; out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b0 || issued_cnt !== 64'd1)
      $display("FAIL flush_handoff: got v=%b cnt=%0d want v=0 cnt=1", out_valid, issued_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      inst      = rand_inst();
      pc        = {$urandom, $urandom};
      rs1_data  = {$urandom, $urandom};
      rs2_data  = {$urandom, $urandom};
      #1;
      n_checks++;
      if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready) || issued_cnt !== m_cnt ||
          (m_valid && dut_pl !== m_exp))
        $display("FAIL rand_c%0d: got v=%b rdy=%b cnt=%0d pl=%h want v=%b cnt=%0d pl=%h",
                 c, out_valid, in_ready, issued_cnt, dut_pl, m_valid, m_cnt, m_exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      inst = addi(5'(c + 1), 12'(c));
      tick();
    end
    in_valid = 0; out_ready = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || issued_cnt !== 64'd7)
      $display("FAIL areset_pre: got v=%b cnt=%0d want v=1 cnt=7", out_valid, issued_cnt);
    else n_pass++;
    #2 rstn = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || issued_cnt !== 64'd0 || dut_pl !== '0)
      $display("FAIL areset_async: got v=%b cnt=%0d pl=%h want all zero", out_valid, issued_cnt, dut_pl);
    else n_pass++;
    m_valid = 0; m_cnt = 0;
    #1 rstn = 1;
    @(posedge clk); #1;
    in_valid = 1; inst = addi(5'd9, 12'hFF0);
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || dut_pl !== m_exp || issued_cnt !== 64'd0)
      $display("FAIL areset_after: got v=%b pl=%h cnt=%0d want v=1 pl=%h cnt=0",
               out_valid, dut_pl, issued_cnt, m_exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
